// File: rtl/programmable_clock_divider_if.sv
// Control and status bundle for the programmable clock divider: run request,
// ratio handshake and divided-clock outputs.
interface programmable_clock_divider_if #(
  parameter int COUNTER_WIDTH = 8
);
  logic                     enable;
  logic [COUNTER_WIDTH-1:0] div_in;
  logic                     div_valid;
  logic                     div_ready;
  logic                     clk_div;
  logic                     tick;
  logic                     busy;

  modport master (
    output enable, div_in, div_valid,
    input  div_ready, clk_div, tick, busy
  );

  modport slave (
    input  enable, div_in, div_valid,
    output div_ready, clk_div, tick, busy
  );
endinterface

// File: rtl/programmable_clock_divider.sv
// Divides clk by a runtime ratio N (high ceil(N/2), low floor(N/2)); ratio
// changes and stop requests only ever take effect on whole-period boundaries.
module programmable_clock_divider #(
  parameter int COUNTER_WIDTH = 8,
  parameter int RESET_DIV     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  programmable_clock_divider_if.slave   bus
);
  localparam int W = COUNTER_WIDTH;
  localparam logic [W-1:0] RESET_RATIO = W'(RESET_DIV);

  if (RESET_DIV < 2 || RESET_DIV >= 2**COUNTER_WIDTH) begin : g_bad_reset_div
    $error("RESET_DIV must satisfy 2 <= RESET_DIV < 2**COUNTER_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t         state;
  logic [W-1:0]   cnt;
  logic [W-1:0]   act;
  logic [W-1:0]   pend;
  logic           pend_vld;
  logic           clk_div_q;
  logic           tick_q;
  logic           busy_q;

  logic [W-1:0]   cnt_nxt;
  logic [W-1:0]   next_ratio;
  logic           boundary;
  logic           accept;

  function automatic logic [W-1:0] clamp_ratio(input logic [W-1:0] n);
    return (n < W'(2)) ? W'(2) : n;
  endfunction

  // High phase covers indices 0 .. ceil(N/2)-1 of the period.
  function automatic logic in_high_phase(input logic [W-1:0] idx,
                                         input logic [W-1:0] n);
    return idx < (n - (n >> 1));
  endfunction

  assign cnt_nxt    = cnt + 1'b1;
  assign boundary   = (cnt == act - 1'b1);
  assign next_ratio = pend_vld ? pend : act;
  assign accept     = bus.div_valid && !pend_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      act       <= RESET_RATIO;
      pend      <= '0;
      pend_vld  <= 1'b0;
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // accept and the pending-clear below are mutually exclusive on pend_vld
      if (accept) begin
        pend     <= clamp_ratio(bus.div_in);
        pend_vld <= 1'b1;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (pend_vld) begin
            act      <= pend;
            pend_vld <= 1'b0;
          end
          if (bus.enable) begin
            state     <= RUN;
            clk_div_q <= 1'b1;
            tick_q    <= 1'b1;
            busy_q    <= 1'b1;
          end else begin
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
          end
        end

        RUN, STOPPING: begin
          if (boundary) begin
            cnt <= '0;
            act <= next_ratio;
            if (pend_vld) pend_vld <= 1'b0;
            if (bus.enable) begin
              state     <= RUN;
              clk_div_q <= 1'b1;
              tick_q    <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              state     <= IDLE;
              clk_div_q <= 1'b0;
              tick_q    <= 1'b0;
              busy_q    <= 1'b0;
            end
          end else begin
            cnt       <= cnt_nxt;
            clk_div_q <= in_high_phase(cnt_nxt, act);
            tick_q    <= 1'b0;
            if (state == RUN && !bus.enable) state <= STOPPING;
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          clk_div_q <= 1'b0;
          tick_q    <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clk_div   = clk_div_q;
  assign bus.tick      = tick_q;
  assign bus.busy      = busy_q;
  assign bus.div_ready = ~pend_vld;
endmodule

// File: tb/tb_programmable_clock_divider.sv
// Scoreboard bench: a period-level reference model queues expected outputs
// each cycle; a negedge monitor pops and compares them against the divider.
module tb_programmable_clock_divider;
  localparam int CW   = 8;
  localparam int RDIV = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  programmable_clock_divider_if #(.COUNTER_WIDTH(CW)) bus ();

  programmable_clock_divider #(.COUNTER_WIDTH(CW), .RESET_DIV(RDIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic clk_div;
    logic tick;
    logic busy;
    logic ready;
  } exp_t;

  exp_t exp_q[$];
  bit   pat_q[$];     // remaining clk_div values of the current period
  bit   m_run;
  int   m_act;
  int   m_pend;
  bit   m_pend_v;
  bit   started = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Reference model: a whole period is laid out when it starts; the next
  // decision is taken when its pattern runs out.
  always @(posedge clk) begin
    exp_t e;
    bit   acc;
    e = '0;
    if (rst) begin
      m_run    = 1'b0;
      m_act    = RDIV;
      m_pend   = 0;
      m_pend_v = 1'b0;
      pat_q.delete();
      e.ready  = 1'b1;
    end else begin
      acc = bus.div_valid && !m_pend_v;
      if (!m_run || pat_q.size() == 0) begin
        if (m_pend_v) begin
          m_act    = m_pend;
          m_pend_v = 1'b0;
        end
        if (bus.enable) begin
          m_run = 1'b1;
          for (int i = 0; i < m_act; i++) pat_q.push_back(i < (m_act - m_act / 2));
          e.tick = 1'b1;
        end else begin
          m_run = 1'b0;
        end
      end
      e.clk_div = m_run ? pat_q.pop_front() : 1'b0;
      if (acc) begin
        m_pend   = (int'(bus.div_in) < 2) ? 2 : int'(bus.div_in);
        m_pend_v = 1'b1;
      end
      e.busy  = m_run;
      e.ready = !m_pend_v;
    end
    exp_q.push_back(e);
    started = 1'b1;
  end

  task automatic check(input string name, input logic act_v, input logic exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act_v, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        e = exp_q.pop_front();
        check("clk_div",   bus.clk_div,   e.clk_div);
        check("tick",      bus.tick,      e.tick);
        check("busy",      bus.busy,      e.busy);
        check("div_ready", bus.div_ready, e.ready);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic write_ratio(input int n);
    bus.div_valid = 1'b1;
    bus.div_in    = CW'(n);
    step();
    bus.div_valid = 1'b0;
  endtask

  task automatic wait_tick();
    for (int k = 0; k < 600; k++) begin
      if (bus.tick === 1'b1) return;
      step();
    end
    total++;
    bad++;
    $display("FAIL tick_timeout at %0t: got no tick expected tick within 600 cycles", $time);
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.div_valid = 1'b0;
    bus.div_in    = '0;
    step(3);

    // Default ratio straight out of reset
    rst = 1'b0;
    bus.enable = 1'b1;
    step(10);

    // Ratio 5 loaded in IDLE
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.enable = 1'b0;
    step(2);
    write_ratio(5);
    step(3);
    bus.enable = 1'b1;
    step(16);

    // Switch to 4, then 7 mid-period
    write_ratio(4);
    step(12);
    wait_tick();
    step();
    write_ratio(7);
    step(22);

    // Stop in the second high cycle of a 6-period, then restart in STOPPING
    write_ratio(6);
    step(8);
    wait_tick();
    step();
    bus.enable = 1'b0;
    step(10);
    bus.enable = 1'b1;
    step(8);
    wait_tick();
    step();
    bus.enable = 1'b0;
    step(2);
    bus.enable = 1'b1;
    step(14);

    // Clamped ratios and the widest ratio
    write_ratio(0);
    step(10);
    write_ratio(1);
    step(10);
    write_ratio(255);
    step(520);

    // Reset during a high phase of 9 with a ratio still pending
    write_ratio(9);
    step(12);
    wait_tick();
    step();
    write_ratio(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(12);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.enable    = ($urandom_range(0, 15) != 0);
      bus.div_valid = ($urandom_range(0, 5) == 0);
      bus.div_in    = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 255))
                                                  : CW'($urandom_range(0, 9));
      rst           = ($urandom_range(0, 299) == 0);
      step();
    end
    rst           = 1'b0;
    bus.div_valid = 1'b0;
    step(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
